mcpu_regfile_mp: RTL and testbench

Parametrised successor of the MCPU register file. Two registered read ports and one write port, with same-cycle write-to-read forwarding and a per-register pending (scoreboard) bit for in-flight loads. A hardware clear sequencer zeroes the array after reset or on request, replacing testbench-side initial zeroing. It sits between the MCPU decode stage (read addresses, pending checks) and the writeback stage (ALU/load results).

---
 rtl/mcpu_regfile_mp.sv | 139 +++++++++++++
 tb/tb_mcpu_regfile_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_regfile_mp.sv
// MCPU register file: two registered read ports, one write port with forwarding,
// per-register pending bits for in-flight loads, and a hardware clear sequencer.
module mcpu_regfile_mp #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REGS    = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int HARDWIRE_R0 = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  pend_a,
    output logic                  pend_b,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pend_set,
    input  logic [ADDR_WIDTH-1:0] pend_addr
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_WIDTH:0]   NREGS = NUM_REGS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   pending, pend_nxt;
    logic                  run_ok, wr_take, ps_take;
    logic [DATA_WIDTH-1:0] rd_nxt_a, rd_nxt_b;
    logic                  pd_nxt_a, pd_nxt_b;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    function automatic logic is_r0hw(input logic [ADDR_WIDTH-1:0] a);
        return (HARDWIRE_R0 != 0) && (a == '0);
    endfunction

    // Handshake: ready is high only in RUN; wr_en, pend_set, clear_req and read
    // addresses take effect only on edges where ready is high, otherwise ignored.
    assign ready   = (state == RUN);
    assign run_ok  = (state == RUN) && !clear_req;
    assign wr_take = run_ok && wr_en && in_range(wr_addr) && !is_r0hw(wr_addr);
    assign ps_take = run_ok && pend_set && in_range(pend_addr) && !is_r0hw(pend_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt == LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A new load issued in the same cycle as a writeback leaves the bit set.
    always_comb begin
        pend_nxt = pending;
        if (!run_ok) begin
            pend_nxt = '0;
        end else begin
            if (wr_take) pend_nxt[wr_addr] = 1'b0;
            if (ps_take) pend_nxt[pend_addr] = 1'b1;
        end
    end

    always_comb begin
        rd_nxt_a = '0;
        rd_nxt_b = '0;
        pd_nxt_a = 1'b0;
        pd_nxt_b = 1'b0;
        if (run_ok && in_range(rd_addr_a) && !is_r0hw(rd_addr_a)) begin
            rd_nxt_a = (wr_take && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
            pd_nxt_a = pend_nxt[rd_addr_a];
        end
        if (run_ok && in_range(rd_addr_b) && !is_r0hw(rd_addr_b)) begin
            rd_nxt_b = (wr_take && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];
            pd_nxt_b = pend_nxt[rd_addr_b];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            pend_a    <= 1'b0;
            pend_b    <= 1'b0;
        end else begin
            pending   <= pend_nxt;
            rd_data_a <= rd_nxt_a;
            rd_data_b <= rd_nxt_b;
            pend_a    <= pd_nxt_a;
            pend_b    <= pd_nxt_b;
        end
    end

    // The array has no reset; the CLEAR sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_take) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mcpu_regfile_mp.sv
// Directed bench for mcpu_regfile_mp: one instance with R0 writable and one
// with R0 hardwired to zero, driven by the same inputs.
module tb_mcpu_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, pend_addr;
    logic [15:0] wr_data;
    logic        wr_en, pend_set;

    logic        ready, pend_a, pend_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        ready_hw, pend_a_hw, pend_b_hw;
    logic [15:0] rd_data_a_hw, rd_data_b_hw;

    int tests  = 0;
    int failed = 0;
    int n;

    always #5 clk = ~clk;

    mcpu_regfile_mp #(.DATA_WIDTH(16), .NUM_REGS(16), .ADDR_WIDTH(4), .HARDWIRE_R0(0)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .pend_a(pend_a), .pend_b(pend_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr)
    );

    mcpu_regfile_mp #(.DATA_WIDTH(16), .NUM_REGS(16), .ADDR_WIDTH(4), .HARDWIRE_R0(1)) dut_hw (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_hw),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a_hw), .rd_data_b(rd_data_b_hw),
        .pend_a(pend_a_hw), .pend_b(pend_b_hw),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts cycles until ready rises, bounded so a stuck sequencer still reports.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clear_req = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pend_set = 1'b0; pend_addr = '0;
        step(); step(); step();

        // Reset state
        chk("rst_ready", ready, 0);
        chk("rst_rd_a", rd_data_a, 0);
        chk("rst_rd_b", rd_data_b, 0);
        chk("rst_pend_a", pend_a, 0);
        chk("rst_pend_b", pend_b, 0);

        // Initial clear sequence takes exactly 16 cycles
        reset = 1'b1;
        wait_ready(n);
        chk("init_clear_cycles", n, 16);
        chk("init_ready_hw", ready_hw, 1);

        // Every register reads zero with no pending bit
        for (int r = 0; r < 16; r++) begin
            rd_addr_a = 4'(r);
            rd_addr_b = 4'(15 - r);
            step();
            chk("init_rd_a", rd_data_a, 0);
            chk("init_rd_b", rd_data_b, 0);
            chk("init_pend_a", pend_a, 0);
        end

        // Basic writes then reads on both ports
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'd40;
        step();
        wr_addr = 4'd5; wr_data = 16'd12;
        step();
        wr_en = 1'b0;
        rd_addr_a = 4'd4; rd_addr_b = 4'd5;
        step();
        chk("rd_r4", rd_data_a, 40);
        chk("rd_r5", rd_data_b, 12);
        rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        step();
        chk("same_addr_a", rd_data_a, 12);
        chk("same_addr_b", rd_data_b, 12);

        // Same-cycle write-to-read forwarding
        wr_en = 1'b1; wr_addr = 4'd14; wr_data = 16'd52; rd_addr_a = 4'd14; rd_addr_b = 4'd4;
        step();
        chk("fwd_r14", rd_data_a, 52);
        chk("nofwd_b_r4", rd_data_b, 40);
        wr_addr = 4'd15; wr_data = 16'd36; rd_addr_a = 4'd15; rd_addr_b = 4'd15;
        step();
        chk("fwd_r15_a", rd_data_a, 36);
        chk("fwd_r15_b", rd_data_b, 36);
        wr_en = 1'b0; rd_addr_b = 4'd14;
        step();
        chk("stored_r15", rd_data_a, 36);
        chk("stored_r14", rd_data_b, 52);

        // Pending bit set, then cleared by writeback
        pend_set = 1'b1; pend_addr = 4'd6; rd_addr_a = 4'd6; rd_addr_b = 4'd5;
        step();
        chk("pend_set_r6", pend_a, 1);
        chk("pend_other_r5", pend_b, 0);
        pend_set = 1'b0;
        step();
        chk("pend_hold_r6", pend_a, 1);
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'd40;
        step();
        chk("pend_clr_r6", pend_a, 0);
        chk("pend_clr_rd_r6", rd_data_a, 40);
        wr_en = 1'b0;
        step();
        chk("pend_after_r6", pend_a, 0);

        // Set wins over a same-cycle write to the same register
        pend_set = 1'b1; pend_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0077;
        rd_addr_b = 4'd7;
        step();
        chk("set_wins_pend", pend_b, 1);
        chk("set_wins_data", rd_data_b, 16'h0077);
        pend_set = 1'b0; wr_en = 1'b0;
        step();
        chk("set_wins_hold", pend_b, 1);

        // R0 behaviour with and without hardwiring
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr_a = 4'd0;
        step();
        chk("r0_fwd", rd_data_a, 16'hFFFF);
        chk("r0_hw_nofwd", rd_data_a_hw, 0);
        wr_en = 1'b0;
        step();
        chk("r0_read", rd_data_a, 16'hFFFF);
        chk("r0_hw_read", rd_data_a_hw, 0);
        chk("r0_hw_pend", pend_a_hw, 0);
        pend_set = 1'b1; pend_addr = 4'd0;
        step();
        pend_set = 1'b0;
        chk("r0_pend", pend_a, 1);
        chk("r0_hw_pend_set", pend_a_hw, 0);

        // Fill the array with nonzero values
        wr_en = 1'b1;
        for (int r = 0; r < 16; r++) begin
            wr_addr = 4'(r);
            wr_data = 16'h1001 + 16'(r * 16'h0111);
            step();
        end
        wr_en = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd12;
        step();
        chk("fill_r3", rd_data_a, 16'h1334);
        chk("fill_r12", rd_data_b, 16'h1CCD);
        pend_set = 1'b1; pend_addr = 4'd9;
        step();
        pend_set = 1'b0;

        // clear_req with a write in the same cycle; the write is dropped
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        step();
        clear_req = 1'b0;
        chk("clr_ready_low", ready, 0);
        chk("clr_rd_zero", rd_data_a, 0);
        // Writes and load marks during clearing are ignored
        wr_addr = 4'd0; wr_data = 16'hDEAD; pend_set = 1'b1; pend_addr = 4'd1;
        wait_ready(n);
        chk("clr_cycles", n, 16);
        wr_en = 1'b0; pend_set = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rd_addr_a = 4'(r);
            rd_addr_b = 4'(r);
            step();
            chk("clr_rd", rd_data_a, 0);
            chk("clr_pend", pend_b, 0);
        end

        // Reset asserted at clear cycle 5 restarts the sequence
        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h1234;
        step();
        wr_en = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        #1;
        chk("midclr_rst_ready", ready, 0);
        chk("midclr_rst_rd", rd_data_a, 0);
        step(); step();
        reset = 1'b1;
        wait_ready(n);
        chk("midclr_cycles", n, 16);
        rd_addr_a = 4'd10;
        step();
        chk("midclr_r10", rd_data_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
